// File: rtl/reg_write_arbiter_if.sv
// Register-file write arbiter bus: two valid/ready write requesters,
// the registered write port and the per-register busy scoreboard.
interface reg_write_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic                       req0_valid;
  logic                       req0_ready;
  logic [ADDR_W-1:0]          req0_reg;
  logic [DATA_W-1:0]          req0_data;
  logic                       req1_valid;
  logic                       req1_ready;
  logic [ADDR_W-1:0]          req1_reg;
  logic [DATA_W-1:0]          req1_data;
  logic                       writeenable;
  logic [ADDR_W-1:0]          writereg;
  logic [DATA_W-1:0]          writedata;
  logic [(1<<ADDR_W)-1:0]     busy;

  // Requesters and register-file side (environment)
  modport master (
    output req0_valid, req0_reg, req0_data,
    output req1_valid, req1_reg, req1_data,
    input  req0_ready, req1_ready,
    input  writeenable, writereg, writedata, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_reg, req0_data,
    input  req1_valid, req1_reg, req1_data,
    output req0_ready, req1_ready,
    output writeenable, writereg, writedata, busy
  );
endinterface

// File: rtl/reg_write_arbiter.sv
// Two-requester register-file write arbiter. Each requester (0 = ALU
// writeback, 1 = load writeback) owns a one-entry holding buffer; one
// buffered write is issued per cycle, and a busy scoreboard flags every
// register with a pending or in-flight write.
// Optional feature: define REGARB_ROUND_ROBIN_EN for round-robin tie
// breaking; otherwise requester 0 always wins ties.
module reg_write_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
) (
  input  logic               clk,
  input  logic               reset,
  reg_write_arbiter_if.slave bus
);
  localparam int NREG = 1 << ADDR_W;

  // Holding buffers (stage p0)
  logic              vld0_p0, vld1_p0;
  logic              rdy0_p0, rdy1_p0;
  logic [ADDR_W-1:0] reg0_p0, reg1_p0;
  logic [DATA_W-1:0] dat0_p0, dat1_p0;
`ifdef REGARB_ROUND_ROBIN_EN
  logic              last_p0;  // 1: requester 1 won the most recent tie
  logic              last_n;
`endif

  // Registered write port and scoreboard (stage p1)
  logic              we_p1;
  logic [ADDR_W-1:0] wreg_p1;
  logic [DATA_W-1:0] wdat_p1;
  logic [NREG-1:0]   busy_p1;

  logic              grant0, grant1;
  logic              take0, take1;
  logic              vld0_n, vld1_n;
  logic              we_n;
  logic [ADDR_W-1:0] reg0_n, reg1_n;
  logic [ADDR_W-1:0] wreg_n;
  logic [DATA_W-1:0] wdat_n;
  logic [NREG-1:0]   busy_n;

  // Arbitration, buffer next-state and scoreboard next-state
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
`ifdef REGARB_ROUND_ROBIN_EN
    last_n = last_p0;
    if (vld0_p0 && vld1_p0) begin
      // Tie goes to whoever did not win the previous tie
      grant0 = last_p0;
      grant1 = ~last_p0;
      last_n = ~last_p0;
    end else begin
      grant0 = vld0_p0;
      grant1 = vld1_p0;
    end
`else
    grant0 = vld0_p0;
    grant1 = vld1_p0 & ~vld0_p0;
`endif
    // Ready comes from the buffer flop, so a buffer drained this edge
    // cannot also be refilled this edge.
    take0  = bus.req0_valid & rdy0_p0;
    take1  = bus.req1_valid & rdy1_p0;
    vld0_n = (vld0_p0 & ~grant0) | take0;
    vld1_n = (vld1_p0 & ~grant1) | take1;
    reg0_n = take0 ? bus.req0_reg : reg0_p0;
    reg1_n = take1 ? bus.req1_reg : reg1_p0;

    we_n   = grant0 | grant1;
    wreg_n = wreg_p1;
    wdat_n = wdat_p1;
    if (grant0) begin
      wreg_n = reg0_p0;
      wdat_n = dat0_p0;
    end else if (grant1) begin
      wreg_n = reg1_p0;
      wdat_n = dat1_p0;
    end

    busy_n = '0;
    if (vld0_n) busy_n[reg0_n] = 1'b1;
    if (vld1_n) busy_n[reg1_n] = 1'b1;
    if (we_n)   busy_n[wreg_n] = 1'b1;
  end

  // Control state: buffer flags, ready, tie pointer, write port, scoreboard
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld0_p0 <= 1'b0;
      vld1_p0 <= 1'b0;
      rdy0_p0 <= 1'b1;
      rdy1_p0 <= 1'b1;
`ifdef REGARB_ROUND_ROBIN_EN
      last_p0 <= 1'b1;
`endif
      we_p1   <= 1'b0;
      wreg_p1 <= '0;
      wdat_p1 <= '0;
      busy_p1 <= '0;
    end else begin
      vld0_p0 <= vld0_n;
      vld1_p0 <= vld1_n;
      rdy0_p0 <= ~vld0_n;
      rdy1_p0 <= ~vld1_n;
`ifdef REGARB_ROUND_ROBIN_EN
      last_p0 <= last_n;
`endif
      we_p1   <= we_n;
      wreg_p1 <= wreg_n;
      wdat_p1 <= wdat_n;
      busy_p1 <= busy_n;
    end
  end

  // Buffer payload, captured on handshake only; qualified by the full flag
  always_ff @(posedge clk) begin
    if (take0) begin
      reg0_p0 <= bus.req0_reg;
      dat0_p0 <= bus.req0_data;
    end
    if (take1) begin
      reg1_p0 <= bus.req1_reg;
      dat1_p0 <= bus.req1_data;
    end
  end

  assign bus.req0_ready  = rdy0_p0;
  assign bus.req1_ready  = rdy1_p0;
  assign bus.writeenable = we_p1;
  assign bus.writereg    = wreg_p1;
  assign bus.writedata   = wdat_p1;
  assign bus.busy        = busy_p1;
endmodule
